// File: rtl/gshare_predictor.sv
// gshare branch direction predictor.
// The pattern history table (PHT) holds saturating counters and is indexed by
// pc XOR speculative global history. The speculative history is repaired from
// execute on a mispredict. Resolved-branch and mispredict counts are kept as
// saturating statistics.
module gshare_predictor #(
    parameter int         INDEX_BITS = 4,
    parameter int         HIST_BITS  = 4,
    parameter int         CTR_BITS   = 2,
    parameter int         CTR_INIT   = 2,
    parameter logic [5:0] OPC_BEQ    = 6'd4,
    parameter logic [5:0] OPC_BNE    = 6'd5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode_F,
    input  logic [INDEX_BITS-1:0] pc_F,
    input  logic                  stall_F,
    output logic                  prediction_F,
    output logic [INDEX_BITS-1:0] index_F,
    output logic [HIST_BITS-1:0]  ghr_F,
    input  logic                  update_E,
    input  logic                  taken_E,
    input  logic                  mispredict_E,
    input  logic [INDEX_BITS-1:0] index_E,
    input  logic [HIST_BITS-1:0]  ghr_E,
    output logic [HIST_BITS-1:0]  ghr_spec,
    output logic [15:0]           stat_branches,
    output logic [15:0]           stat_mispred
);

    localparam int                  DEPTH   = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);
    localparam logic [15:0]         STAT_MAX = 16'hFFFF;

    logic [CTR_BITS-1:0]   r_pht [DEPTH];
    logic [HIST_BITS-1:0]  r_ghr;
    logic [15:0]           r_stat_branches;
    logic [15:0]           r_stat_mispred;

    logic                  w_is_br;
    logic [INDEX_BITS-1:0] w_index;
    logic [CTR_BITS-1:0]   w_ctr_rd;
    logic                  w_pred;
    logic [CTR_BITS-1:0]   w_ctr_old;
    logic [CTR_BITS-1:0]   w_ctr_new;
    logic [HIST_BITS-1:0]  w_ghr_next;

    // Fetch-side lookup: hash the PC with the speculative history and read the counter.
    assign w_is_br  = (opcode_F == OPC_BEQ) || (opcode_F == OPC_BNE);
    assign w_index  = pc_F ^ INDEX_BITS'(r_ghr);
    assign w_ctr_rd = r_pht[w_index];
    assign w_pred   = w_is_br & w_ctr_rd[CTR_BITS-1];

    assign prediction_F  = w_pred;
    assign index_F       = w_index;
    assign ghr_F         = r_ghr;
    assign ghr_spec      = r_ghr;
    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;

    // Next speculative history: a repair from execute overrides any fetch shift.
    always_comb begin
        // NOTE: default assignment first so every path drives w_ghr_next and no latch is inferred.
        w_ghr_next = r_ghr;
        if (update_E && mispredict_E) begin
            // Casting the concatenation down keeps the low HIST_BITS, which also
            // covers HIST_BITS == 1 where the history is just the new bit.
            w_ghr_next = HIST_BITS'({ghr_E, taken_E});
        end else if (w_is_br && !stall_F) begin
            w_ghr_next = HIST_BITS'({r_ghr, w_pred});
        end
    end

    // Saturating increment/decrement of the counter being resolved in execute.
    always_comb begin
        w_ctr_old = r_pht[index_E];
        w_ctr_new = w_ctr_old;
        if (taken_E) begin
            if (w_ctr_old != CTR_MAX) w_ctr_new = w_ctr_old + CTR_BITS'(1);
        end else begin
            if (w_ctr_old != '0) w_ctr_new = w_ctr_old - CTR_BITS'(1);
        end
    end

    // PHT storage: all entries return to the initial counter value on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the PHT is a small flop array, so resetting every entry is cheap and
            // gives a defined start; a large RAM-backed table would be initialised differently.
            for (int i = 0; i < DEPTH; i++) begin
                r_pht[i] <= CTR_RST;
            end
        end else if (update_E) begin
            // NOTE: sequential state uses non-blocking assignments so the fetch read
            // in this cycle still sees the pre-update counter.
            r_pht[index_E] <= w_ctr_new;
        end
    end

    // Speculative global history register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_next;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else if (update_E) begin
            if (r_stat_branches != STAT_MAX) r_stat_branches <= r_stat_branches + 16'd1;
            if (mispredict_E && (r_stat_mispred != STAT_MAX)) r_stat_mispred <= r_stat_mispred + 16'd1;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_gshare_predictor;

    localparam int IB = 4;
    localparam int HB = 4;
    localparam int CB = 2;
    localparam int CI = 2;
    localparam int N_ENT    = 1 << IB;
    localparam int HIST_MOD = 1 << HB;
    localparam int CTR_TOP  = (1 << CB) - 1;
    localparam int CTR_HALF = 1 << (CB - 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode_F;
    logic [IB-1:0] pc_F;
    logic          stall_F;
    logic          prediction_F;
    logic [IB-1:0] index_F;
    logic [HB-1:0] ghr_F;
    logic          update_E;
    logic          taken_E;
    logic          mispredict_E;
    logic [IB-1:0] index_E;
    logic [HB-1:0] ghr_E;
    logic [HB-1:0] ghr_spec;
    logic [15:0]   stat_branches;
    logic [15:0]   stat_mispred;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    gshare_predictor #(
        .INDEX_BITS(IB), .HIST_BITS(HB), .CTR_BITS(CB), .CTR_INIT(CI),
        .OPC_BEQ(6'd4), .OPC_BNE(6'd5)
    ) dut (
        .clk(clk), .reset(reset),
        .opcode_F(opcode_F), .pc_F(pc_F), .stall_F(stall_F),
        .prediction_F(prediction_F), .index_F(index_F), .ghr_F(ghr_F),
        .update_E(update_E), .taken_E(taken_E), .mispredict_E(mispredict_E),
        .index_E(index_E), .ghr_E(ghr_E),
        .ghr_spec(ghr_spec), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    // ---------------- behavioural model ----------------
    int m_pht [N_ENT];
    int m_ghr;
    int m_br;
    int m_mp;
    bit m_p;

    function automatic bit m_is_br();
        return (opcode_F == 6'd4) || (opcode_F == 6'd5);
    endfunction

    function automatic int m_index();
        return int'(pc_F) ^ m_ghr;
    endfunction

    function automatic bit m_pred();
        return m_is_br() && (m_pht[m_index()] >= CTR_HALF);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENT; i++) m_pht[i] = CI;
            m_ghr = 0;
            m_br  = 0;
            m_mp  = 0;
        end else begin
            m_p = m_pred();
            if (update_E && mispredict_E)
                m_ghr = (int'(ghr_E) * 2 + int'(taken_E)) % HIST_MOD;
            else if (m_is_br() && !stall_F)
                m_ghr = (m_ghr * 2 + int'(m_p)) % HIST_MOD;
            if (update_E) begin
                if (taken_E) begin
                    if (m_pht[index_E] < CTR_TOP) m_pht[index_E] = m_pht[index_E] + 1;
                end else begin
                    if (m_pht[index_E] > 0) m_pht[index_E] = m_pht[index_E] - 1;
                end
                if (m_br < 65535) m_br = m_br + 1;
                if (mispredict_E && m_mp < 65535) m_mp = m_mp + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp prediction_F", 32'(prediction_F), 32'(m_pred()));
            check("cmp index_F",      32'(index_F),      32'(m_index()));
            check("cmp ghr_F",        32'(ghr_F),        32'(m_ghr));
            check("cmp ghr_spec",     32'(ghr_spec),     32'(m_ghr));
            check("cmp stat_branches", 32'(stat_branches), 32'(m_br));
            check("cmp stat_mispred", 32'(stat_mispred),  32'(m_mp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        opcode_F = 6'd0; pc_F = '0; stall_F = 1'b0;
        update_E = 1'b0; taken_E = 1'b0; mispredict_E = 1'b0;
        index_E = '0; ghr_E = '0;
    endtask

    task automatic randomize_inputs();
        case ($urandom_range(0, 3))
            0: opcode_F = 6'd4;
            1: opcode_F = 6'd5;
            2: opcode_F = 6'd0;
            default: opcode_F = 6'($urandom);
        endcase
        pc_F         = IB'($urandom);
        stall_F      = ($urandom_range(0, 3) == 0);
        update_E     = $urandom_range(0, 1) == 1;
        taken_E      = $urandom_range(0, 1) == 1;
        mispredict_E = ($urandom_range(0, 2) == 0);
        index_E      = IB'($urandom);
        ghr_E        = HB'($urandom);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset  = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("reset ghr_spec", 32'(ghr_spec), 32'h0);
        check("reset stat_branches", 32'(stat_branches), 32'h0);
        check("reset stat_mispred", 32'(stat_mispred), 32'h0);

        // beq at pc 3 after reset, then bne at pc 3 with history 0001
        opcode_F = 6'd4; pc_F = 4'd3;
        #1;
        check("beq index_F", 32'(index_F), 32'd3);
        check("beq prediction_F", 32'(prediction_F), 32'd1);
        check("beq ghr_F", 32'(ghr_F), 32'd0);
        step();
        check("shift ghr_spec", 32'(ghr_spec), 32'b0001);
        opcode_F = 6'd5; pc_F = 4'd3;
        #1;
        check("bne index_F", 32'(index_F), 32'd2);
        step();
        check("second shift ghr_spec", 32'(ghr_spec), 32'b0011);

        // non-branch and stalled branch leave history alone
        opcode_F = 6'd0;
        #1;
        check("nonbranch prediction_F", 32'(prediction_F), 32'd0);
        step();
        check("nonbranch ghr_spec", 32'(ghr_spec), 32'b0011);
        opcode_F = 6'd4; stall_F = 1'b1;
        step();
        check("stalled ghr_spec", 32'(ghr_spec), 32'b0011);

        // counter at index 5: decrement to floor, then increment to ceiling
        update_E = 1'b1; taken_E = 1'b0; index_E = 4'd5;
        repeat (3) step();
        update_E = 1'b0; pc_F = 4'd6;
        #1;
        check("floor index_F", 32'(index_F), 32'd5);
        check("floor prediction_F", 32'(prediction_F), 32'd0);
        update_E = 1'b1; taken_E = 1'b1;
        repeat (5) step();
        update_E = 1'b0;
        #1;
        check("ceiling prediction_F", 32'(prediction_F), 32'd1);
        check("eight updates stat_branches", 32'(stat_branches), 32'd8);

        // repair race
        reset = 1'b1;
        step();
        reset = 1'b0;
        opcode_F = 6'd4; pc_F = 4'd0; stall_F = 1'b0;
        update_E = 1'b1; mispredict_E = 1'b1; ghr_E = 4'b1010; taken_E = 1'b1; index_E = 4'd0;
        step();
        update_E = 1'b0; mispredict_E = 1'b0; opcode_F = 6'd0;
        #1;
        check("repair ghr_spec", 32'(ghr_spec), 32'b0101);
        check("repair stat_mispred", 32'(stat_mispred), 32'd1);
        check("repair stat_branches", 32'(stat_branches), 32'd1);

        // same-entry read/write at index 7 (counter 1 before the taken update)
        update_E = 1'b1; taken_E = 1'b0; index_E = 4'd7;
        step();
        opcode_F = 6'd4; pc_F = 4'd2; stall_F = 1'b1;
        taken_E = 1'b1;
        #1;
        check("race index_F", 32'(index_F), 32'd7);
        check("race old prediction_F", 32'(prediction_F), 32'd0);
        step();
        update_E = 1'b0;
        #1;
        check("race new prediction_F", 32'(prediction_F), 32'd1);

        // drive index 5 to 0, then reset alongside an update and mispredict
        update_E = 1'b1; taken_E = 1'b0; index_E = 4'd5;
        repeat (2) step();
        update_E = 1'b0; pc_F = 4'd0;
        #1;
        check("pre-reset prediction idx5", 32'(prediction_F), 32'd0);
        reset = 1'b1; update_E = 1'b1; mispredict_E = 1'b1; ghr_E = 4'hF; taken_E = 1'b0;
        step();
        reset = 1'b0; update_E = 1'b0; mispredict_E = 1'b0; pc_F = 4'd5;
        #1;
        check("reset race ghr_spec", 32'(ghr_spec), 32'h0);
        check("reset race stat_branches", 32'(stat_branches), 32'h0);
        check("reset race stat_mispred", 32'(stat_mispred), 32'h0);
        check("reset race index_F", 32'(index_F), 32'd5);
        check("reset race prediction_F", 32'(prediction_F), 32'd1);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        // statistics saturation
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 0; n < 65540; n++) begin
            randomize_inputs();
            update_E = 1'b1; mispredict_E = 1'b1;
            step();
        end
        idle_inputs();
        #1;
        check("saturated stat_branches", 32'(stat_branches), 32'hFFFF);
        check("saturated stat_mispred", 32'(stat_mispred), 32'hFFFF);
        step();
        check("held stat_branches", 32'(stat_branches), 32'hFFFF);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare conditional-branch direction predictor for the pipelined core. It supersedes the fixed 16-entry, externally-historied predictor. It owns a speculative global history register (GHR), indexes a pattern history table (PHT) of N-bit saturating counters with PC XOR history, and repairs history on mispredict. It also keeps branch and mispredict statistics. It sits beside the fetch stage; resolution arrives from execute.

## Interface
Parameters:
- INDEX_BITS, 4: PHT index width; the PHT has 2^INDEX_BITS entries.
- HIST_BITS, 4: GHR width; legal range 1..INDEX_BITS.
- CTR_BITS, 2: saturating counter width; must be at least 1.
- CTR_INIT, 2: counter value loaded on reset (2 = weakly taken).
- OPC_BEQ, 6'd4: opcode of beq.
- OPC_BNE, 6'd5: opcode of bne.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- opcode_F, in, 6: opcode of the instruction in fetch.
- pc_F, in, INDEX_BITS: low PC bits of the instruction in fetch.
- stall_F, in, 1: fetch held; the GHR must not shift.
- prediction_F, out, 1: combinational; 1 means predict taken.
- index_F, out, INDEX_BITS: PHT index used in fetch; carried down the pipeline.
- ghr_F, out, HIST_BITS: GHR value before this fetch's shift; carried down the pipeline.
- update_E, in, 1: a resolved beq/bne is in execute.
- taken_E, in, 1: actual outcome.
- mispredict_E, in, 1: only meaningful when update_E=1.
- index_E, in, INDEX_BITS: index_F carried to execute.
- ghr_E, in, HIST_BITS: ghr_F carried to execute.
- ghr_spec, out, HIST_BITS: current speculative GHR (debug).
- stat_branches, out, 16: resolved branch count, saturating.
- stat_mispred, out, 16: mispredict count, saturating.

## Operation
Fetch (combinational):
- index_F = pc_F XOR zero-extend(ghr_spec).
- is_br_F = (opcode_F == OPC_BEQ) or (opcode_F == OPC_BNE).
- prediction_F = is_br_F AND the MSB of PHT[index_F]. Otherwise it is 0.
- ghr_F = ghr_spec.

GHR next-state, in priority order:
1. reset: ghr_spec becomes 0.
2. update_E AND mispredict_E: ghr_spec becomes {ghr_E[HIST_BITS-2:0], taken_E}. This is a repair; any fetch shift in the same cycle is discarded.
3. is_br_F AND NOT stall_F: ghr_spec becomes {ghr_spec[HIST_BITS-2:0], prediction_F}.
4. Otherwise ghr_spec holds.
- When HIST_BITS=1, a shift means ghr_spec simply becomes the new bit.

PHT update, when update_E=1:
- taken_E=1: PHT[index_E] increments, saturating at 2^CTR_BITS-1.
- taken_E=0: PHT[index_E] decrements, saturating at 0.
- Counter arithmetic is CTR_BITS wide with no wrap.
- Only one entry is written per cycle.

Statistics:
- stat_branches increments on each update_E=1.
- stat_mispred increments on each update_E AND mispredict_E.
- Both counters saturate at 16'hFFFF.

Reset:
- All PHT entries are set to CTR_INIT.
- ghr_spec and both statistics counters are set to 0.
- Reset takes priority over every simultaneous update and shift, including mid-operation.

## Timing
- Prediction has zero-cycle latency: combinational from opcode_F, pc_F, the PHT and ghr_spec.
- A PHT write at an edge is visible to fetch reads from the next cycle.
- Same-cycle read and write to one entry: the read returns the pre-update value.
- GHR shift or repair takes effect at the next edge.
- A fetch in the cycle right after a repair uses the repaired history.
- Output values after reset:
  - prediction_F = 0 for non-branches.
  - prediction_F = MSB of CTR_INIT for branches.
  - ghr_spec = 0, ghr_F = 0, index_F = pc_F, stat_branches = 0, stat_mispred = 0.
- update_E with mispredict_E=0 never touches the GHR.
- stall_F does not block PHT updates or repairs.

## Test plan
- Reset, then beq at pc_F=3: index_F=3 and prediction_F=1 (counter 2). The next cycle ghr_spec=4'b0001; bne at pc_F=3 now gives index_F=2.
- Non-branch opcode (6'd0) with any PHT contents: prediction_F=0 and ghr_spec unchanged. A beq with stall_F=1 also leaves ghr_spec unchanged.
- Three update_E pulses with taken_E=0 at index_E=5: the counter goes 2, 1, 0 and stays at 0. A beq then fetched at index 5 gives prediction_F=0. Four taken updates at the same index saturate it at 3.
- Repair race: update_E=1, mispredict_E=1, ghr_E=4'b1010, taken_E=1 while beq is in fetch with stall_F=0. Next cycle ghr_spec=4'b0101 and the fetch shift is lost. stat_mispred=1 and stat_branches=1.
- Same-entry race: update_E taken at index 7 while fetch reads index 7 with counter 1. prediction_F=0 this cycle and 1 the next.
- Reset asserted in the same cycle as update_E and mispredict_E: the PHT returns to CTR_INIT and ghr_spec=0. Separately, force 65536 updates: stat_branches holds at 16'hFFFF.
